ps2_host_tx: RTL and testbench

// Host-to-device PS/2 transmitter: sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.

---
 rtl/ps2_host_tx_pkg.sv | 37 +++
 rtl/ps2_line_sync.sv | 38 +++
 rtl/ps2_host_tx.sv | 162 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_tx_pkg.sv
`default_nettype none
// ============================================================================
// ps2_host_tx_pkg : shared state encodings, PS/2 command bytes, timing defaults
// Revision 1.0
// ============================================================================
package ps2_host_tx_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_RTS       = 3'd2;
  localparam logic [2:0] ST_SHIFT     = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;
  localparam logic [2:0] ST_FAIL      = 3'd6;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] RSP_ACK     = 8'hFA;

  localparam int DEF_CLK_FREQ_HZ = 50_000_000;
  localparam int DEF_INHIBIT_CYC = 6_000;
  localparam int DEF_RTS_TO_CYC  = 750_000;
  localparam int DEF_PKT_TO_CYC  = 100_000;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
// ps2_line_sync : 2-FF synchronizer for PS2_CLK/PS2_DAT with clock falling-edge pulse
// Revision 1.0
// ============================================================================
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_pin_i,
  input  logic dat_pin_i,
  output logic clk_s_o,
  output logic dat_s_o,
  output logic clk_fall_o
);

  logic [1:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic       clk_prev_q;

  // Idle bus level is high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], clk_pin_i};
      dat_sync_q <= {dat_sync_q[0], dat_pin_i};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign clk_s_o    = clk_sync_q[1];
  assign dat_s_o    = dat_sync_q[1];
  assign clk_fall_o = clk_prev_q & ~clk_sync_q[1];

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// ps2_host_tx : host-to-device PS/2 command transmitter (inhibit, RTS, shift, ACK)
// Revision 1.0
// ============================================================================
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int INHIBIT_CYC = DEF_INHIBIT_CYC,
  parameter int RTS_TO_CYC  = DEF_RTS_TO_CYC,
  parameter int PKT_TO_CYC  = DEF_PKT_TO_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  // The inhibit hold is never allowed below 100 us at the given clock.
  localparam int INH_MIN = CLK_FREQ_HZ / 10_000;
  localparam int INH_CYC = (INHIBIT_CYC > INH_MIN) ? INHIBIT_CYC : INH_MIN;
  localparam int CNT_W   = $clog2(max3(INH_CYC, RTS_TO_CYC, PKT_TO_CYC) + 1);

  localparam logic [CNT_W-1:0] INH_LOAD = CNT_W'(INH_CYC - 1);
  localparam logic [CNT_W-1:0] RTS_LOAD = CNT_W'(RTS_TO_CYC - 1);
  localparam logic [CNT_W-1:0] PKT_LOAD = CNT_W'(PKT_TO_CYC - 1);

  logic             clk_s, dat_s, clk_fall;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       shift_q, shift_d;
  logic [3:0]       edge_q, edge_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  ps2_line_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_pin_i  (ps2_clk_in),
    .dat_pin_i  (ps2_dat_in),
    .clk_s_o    (clk_s),
    .dat_s_o    (dat_s),
    .clk_fall_o (clk_fall)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    shift_d  = shift_q;
    edge_d   = edge_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx_valid) begin
          shift_d  = {1'b1, odd_parity(tx_data), tx_data};
          cnt_d    = INH_LOAD;
          edge_d   = 4'd0;
          clk_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == '0) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          cnt_d    = RTS_LOAD;
          state_d  = ST_RTS;
        end
      end
      ST_RTS: begin
        if (clk_fall) begin
          dat_oe_d = ~shift_q[0];
          shift_d  = {1'b0, shift_q[9:1]};
          edge_d   = 4'd1;
          cnt_d    = PKT_LOAD;
          state_d  = ST_SHIFT;
        end else if (cnt_q == '0) begin
          state_d = ST_FAIL;
        end
      end
      ST_SHIFT: begin
        if (clk_fall) begin
          dat_oe_d = ~shift_q[0];
          shift_d  = {1'b0, shift_q[9:1]};
          edge_d   = edge_q + 4'd1;
          // Edge 10 puts the stop bit out; the next edge is the device ACK.
          if (edge_q == 4'd9) state_d = ST_ACK;
        end else if (cnt_q == '0) begin
          state_d = ST_FAIL;
        end
      end
      ST_ACK: begin
        if (clk_fall) state_d = dat_s ? ST_FAIL : ST_WAIT_IDLE;
        else if (cnt_q == '0) state_d = ST_FAIL;
      end
      ST_WAIT_IDLE: begin
        if (clk_s && dat_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_FAIL;
        end
      end
      ST_FAIL: begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_FAIL) begin
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      edge_q   <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      edge_q   <= edge_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign tx_ready   = (state_q == ST_IDLE);
  assign busy       = ~tx_ready;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign tx_done    = done_q;
  assign tx_error   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// tb_ps2_host_tx : directed bench with a PS/2 device model on the open-drain pair
// Revision 1.0
// ============================================================================
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int HP = 40;  // device half clock period in system cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_error;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  wire        clk_line = ~ps2_clk_oe & ~dev_clk_low;
  wire        dat_line = ~ps2_dat_oe & ~dev_dat_low;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_FREQ_HZ (500_000),
    .INHIBIT_CYC (60),
    .RTS_TO_CYC  (2000),
    .PKT_TO_CYC  (3000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (clk_line),
    .ps2_dat_in (dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) err_cnt <= err_cnt + 1;
    if (tx_done && tx_error) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  logic [9:0] rx_bits;
  int         inh_cyc;
  logic       rts_seen;
  logic       clk_drv_seen;
  logic       frame_ok;

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device model: measures the inhibit, checks RTS, clocks up to 'edges' falling
  // edges sampling data on rising edges, and optionally ACKs on edge 11.
  task automatic dev_frame(input int edges, input logic ack);
    int t;
    rx_bits = '0; inh_cyc = 0; rts_seen = 1'b0; clk_drv_seen = 1'b0; frame_ok = 1'b1;
    t = 0;
    while (!ps2_clk_oe && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) begin frame_ok = 1'b0; return; end
    while (ps2_clk_oe && inh_cyc < 1000) begin inh_cyc++; @(negedge clk); end
    rts_seen = ps2_dat_oe & clk_line;
    if (edges == 0) return;
    repeat (HP) @(negedge clk);
    for (int e = 1; e <= 10 && e <= edges; e++) begin
      dev_clk_low = 1'b1;
      repeat (HP) @(negedge clk);
      if (ps2_clk_oe) clk_drv_seen = 1'b1;
      dev_clk_low = 1'b0;
      rx_bits[e-1] = dat_line;
      repeat (HP) @(negedge clk);
    end
    if (edges < 11) return;
    if (ack) dev_dat_low = 1'b1;
    repeat (HP/2) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HP) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (HP) @(negedge clk);
    dev_dat_low = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic full_frame(input string tag, input logic [7:0] exp_d, input logic exp_p);
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    dev_frame(11, 1'b1);
    repeat (2) @(negedge clk);
    check({tag, "_data"},   {24'd0, rx_bits[7:0]}, {24'd0, exp_d});
    check({tag, "_parity"}, {31'd0, rx_bits[8]}, {31'd0, exp_p});
    check({tag, "_done"},   done_cnt - d0, 1);
    check({tag, "_err"},    err_cnt - e0, 0);
  endtask

  initial begin
    int d0, e0, t;
    logic [7:0] cmd;

    // Reset state
    #12;
    check("rst_ready",  {31'd0, tx_ready},   1);
    check("rst_busy",   {31'd0, busy},       0);
    check("rst_clk_oe", {31'd0, ps2_clk_oe}, 0);
    check("rst_dat_oe", {31'd0, ps2_dat_oe}, 0);
    check("rst_done",   {31'd0, tx_done},    0);
    check("rst_err",    {31'd0, tx_error},   0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1. Set-LEDs command: inhibit length, RTS, bits, ACK
    cmd = CMD_SET_LED;
    d0 = done_cnt; e0 = err_cnt;
    send(cmd);
    check("t1_busy", {31'd0, busy}, 1);
    dev_frame(11, 1'b1);
    repeat (2) @(negedge clk);
    check("t1_ok",       {31'd0, frame_ok}, 1);
    check("t1_inhibit",  inh_cyc, 60);
    check("t1_rts",      {31'd0, rts_seen}, 1);
    check("t1_data",     {24'd0, rx_bits[7:0]}, 32'hED);
    check("t1_parity",   {31'd0, rx_bits[8]}, 1);
    check("t1_stop",     {31'd0, rx_bits[9]}, 1);
    check("t1_clk_free", {31'd0, clk_drv_seen}, 0);
    check("t1_done",     done_cnt - d0, 1);
    check("t1_err",      err_cnt - e0, 0);
    check("t1_ready",    {31'd0, tx_ready}, 1);

    // 2. Parity corner bytes
    send(8'h01); full_frame("t2a", 8'h01, 1'b0);
    send(8'h00); full_frame("t2b", 8'h00, 1'b1);

    // 3. Device never clocks after RTS
    d0 = done_cnt; e0 = err_cnt;
    send(CMD_RESET);
    dev_frame(0, 1'b0);
    t = 0;
    while (!tx_error && t < 4000) begin @(negedge clk); t++; end
    check("t3_timing",  {31'd0, (t >= 1995 && t <= 2010)}, 1);
    check("t3_clk_oe",  {31'd0, ps2_clk_oe}, 0);
    check("t3_dat_oe",  {31'd0, ps2_dat_oe}, 0);
    check("t3_ready",   {31'd0, tx_ready}, 1);
    repeat (2) @(negedge clk);
    check("t3_err",     err_cnt - e0, 1);
    check("t3_done",    done_cnt - d0, 0);

    // 4. No ACK from device
    d0 = done_cnt; e0 = err_cnt;
    send(8'h55);
    dev_frame(11, 1'b0);
    check("t4_data", {24'd0, rx_bits[7:0]}, 32'h55);
    check("t4_err",  err_cnt - e0, 1);
    check("t4_done", done_cnt - d0, 0);

    // 5. Reset mid-frame after edge 5, then a clean Enable
    d0 = done_cnt; e0 = err_cnt;
    send(CMD_ENABLE);
    dev_frame(5, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("t5_clk_oe", {31'd0, ps2_clk_oe}, 0);
    check("t5_dat_oe", {31'd0, ps2_dat_oe}, 0);
    check("t5_busy",   {31'd0, busy}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("t5_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
    send(CMD_ENABLE); full_frame("t5", 8'hF4, 1'b0);

    // 6. tx_valid held across a transfer: back-to-back ED then 07
    d0 = done_cnt; e0 = err_cnt;
    @(negedge clk);
    tx_data = CMD_SET_LED; tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h07;
    dev_frame(11, 1'b1);
    check("t6_first",   {24'd0, rx_bits[7:0]}, 32'hED);
    check("t6_rearmed", {31'd0, tx_ready}, 0);
    tx_valid = 1'b0;
    dev_frame(11, 1'b1);
    repeat (2) @(negedge clk);
    check("t6_second",  {24'd0, rx_bits[7:0]}, 32'h07);
    check("t6_par2",    {31'd0, rx_bits[8]}, 0);
    check("t6_done",    done_cnt - d0, 2);
    check("t6_err",     err_cnt - e0, 0);
    repeat (100) @(negedge clk);
    check("t6_idle",    {31'd0, tx_ready}, 1);

    check("excl_pulses", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
